prng_word_packer: RTL
=====================

# prng_word_packer

Downstream consumer of the combined 8-bit LFSR PRNG output. Gathers consecutive valid PRNG bytes into 32-bit words, buffers them in a small FIFO, and presents them on a valid/ready stream to the random-number consumers in the mixed-signal system. The PRNG source is free-running and cannot be stalled, so overflow is handled by counted word drops. An optional repetition-count health test flags a stuck generator.

## Interface
- SAMPLE_W, 8, width of one PRNG sample
- PACK, 4, samples per output word; word width is SAMPLE_W*PACK
- DEPTH, 4, FIFO depth in words; power of two, ≥2
- RCT_LIMIT, 4, consecutive identical samples that trip the health test; range 2..255
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, synchronous, active-low
- sample_i  in  SAMPLE_W  PRNG byte (the XOR-combined LFSR output)
- sample_valid_i  in  1  sample_i is valid this cycle
- word_o  out  SAMPLE_W*PACK  head-of-FIFO word
- word_valid_o  out  1  word_o is valid
- word_ready_i  in  1  consumer accepts word_o
- fill_o  out  clog2(DEPTH)+1  words currently in the FIFO
- drop_cnt_o  out  8  completed words discarded because the FIFO was full; saturates at 255
- health_fail_o  out  1  sticky repetition-count failure

## Operation
- Packer: 2-bit index idx (0..PACK-1) and a shift register.
  - An accepted sample (sample_valid_i=1 and not failed) is written to bits [idx*SAMPLE_W +: SAMPLE_W]. The first sample lands in [7:0].
  - idx increments on each accepted sample and wraps from PACK-1 to 0.
- Word complete: the sample accepted at idx=PACK-1 completes a word, which is pushed that cycle.
  - Push succeeds if the FIFO is not full, or if it is full and a pop occurs in the same cycle.
  - Otherwise the word is dropped and drop_cnt_o increments (saturating). The packer restarts at idx=0 either way.
- FIFO: a pop occurs when word_valid_o && word_ready_i.
  - word_valid_o = (fill_o != 0).
  - word_o is stable while word_valid_o=1 and word_ready_i=0.
- Health test (macro-controlled):
  - Tracks the previous accepted sample and a repeat counter rep.
  - A new sample equal to the previous one gives rep+1; a different sample sets rep to 1.
  - When rep reaches RCT_LIMIT, health_fail_o sets on the next edge and holds until reset.
  - While failed, all samples are ignored, idx is frozen, and the partial word is discarded. The FIFO still drains normally.
- Reset (rst_n=0 at a clock edge): idx=0, partial word cleared, FIFO emptied, fill_o=0, word_valid_o=0, word_o=0, drop_cnt_o=0, health_fail_o=0, rep=0.
  - Reset asserted mid-word or with a full FIFO discards all contents; there is no flush.

## Timing
- Latency: the PACK-th byte is accepted at edge N; word_valid_o=1 and word_o is valid after edge N (visible in cycle N+1) if the FIFO was empty.
- Throughput: one word per PACK valid samples. Sustained output is 1 word per 4 cycles, so the FIFO never overflows while the consumer is always ready.
- fill_o and word_valid_o update on the same edge as the push or pop. Simultaneous push and pop leaves fill_o unchanged.
- health_fail_o rises on the edge that accepts the RCT_LIMIT-th identical sample. That sample is not packed.
- drop_cnt_o updates on the edge of the dropped completion.

## Configuration
- PRNG_HEALTH_EN defined: the repetition-count test is compiled in, as described above.
- PRNG_HEALTH_EN undefined: no comparator, previous-sample register or rep counter. health_fail_o is tied to 0 and every valid sample is accepted.

## Structure
- Shared package prng_pkg:
  - SAMPLE_W, PACK, WORD_W = SAMPLE_W*PACK, DEPTH, RCT_LIMIT defaults
  - typedef word_t (logic [WORD_W-1:0]), shared with the LFSR blocks and the consumers
- Sub-module prng_sync_fifo:
  - synchronous FIFO, WORD_W × DEPTH, registered read data
  - push, pop, full, empty, count
  - rst_n synchronous active-low
  - full-with-pop push allowed
- The top level holds the packer, drop counter and health test.

## Test plan
- Reset, then samples 0x11,0x22,0x33,0x44 valid on consecutive cycles, word_ready_i=1 -> word_o=0x44332211 with word_valid_o=1 for one cycle, one cycle after the 4th sample; fill_o returns to 0.
- Gaps: the same four samples with sample_valid_i low on alternate cycles -> identical word; invalid cycles do not advance idx.
- Overflow: word_ready_i=0, 5 complete words (20 distinct samples) -> fill_o=4 and drop_cnt_o=1. The 5th word is lost; the first 4 words drain in order once ready is raised.
- Full plus simultaneous pop: FIFO full, word_ready_i=1 on the cycle the next word completes -> push accepted, fill_o stays 4, drop_cnt_o unchanged.
- Health test (PRNG_HEALTH_EN): 0xA5 repeated 4 times -> health_fail_o=1 after the 4th edge; further samples produce no words. A 3-repeat run followed by 0x5A does not trip. Without the macro, the same stimulus gives health_fail_o=0 and word 0xA5A5A5A5.
- Reset mid-operation: rst_n low for 1 cycle after 2 samples with 2 words buffered -> all outputs return to reset values. The next 4 samples form a fresh word with the first sample in [7:0].

Source files
------------

// File: rtl/prng_pkg.sv
// prng_pkg
// Shared constants and types for the PRNG word path. word_t is the word
// type used by the LFSR blocks, the packer and the random-number consumers.
//   SAMPLE_W  - width of one PRNG sample
//   PACK      - samples per word
//   WORD_W    - packed word width
//   DEPTH     - word FIFO depth (power of two, >= 2)
//   RCT_LIMIT - identical consecutive samples that trip the health test
package prng_pkg;
    localparam int SAMPLE_W  = 8;
    localparam int PACK      = 4;
    localparam int WORD_W    = SAMPLE_W * PACK;
    localparam int DEPTH     = 4;
    localparam int RCT_LIMIT = 4;
    localparam int IDX_W     = $clog2(PACK);
    localparam int FILL_W    = $clog2(DEPTH) + 1;

    typedef logic [WORD_W-1:0]   word_t;
    typedef logic [SAMPLE_W-1:0] sample_t;
endpackage

// File: rtl/prng_word_packer_if.sv
// prng_word_packer_if
// Sample input, word stream and status signals of the word packer.
//   slave  - packer side (takes samples and ready, drives words and status)
//   master - environment side (drives samples and ready)
interface prng_word_packer_if;
    import prng_pkg::*;

    sample_t           sample_i;
    logic              sample_valid_i;
    word_t             word_o;
    logic              word_valid_o;
    logic              word_ready_i;
    logic [FILL_W-1:0] fill_o;
    logic [7:0]        drop_cnt_o;
    logic              health_fail_o;

    modport slave (
        input  sample_i, sample_valid_i, word_ready_i,
        output word_o, word_valid_o, fill_o, drop_cnt_o, health_fail_o
    );

    modport master (
        output sample_i, sample_valid_i, word_ready_i,
        input  word_o, word_valid_o, fill_o, drop_cnt_o, health_fail_o
    );
endinterface

// File: rtl/prng_sync_fifo.sv
// prng_sync_fifo
// Synchronous word FIFO with a registered head-of-queue output.
//   clk, rst_n - clock, synchronous active-low reset
//   i_push     - write i_wdata (accepted when not full, or full with a pop)
//   i_pop      - remove the head word (ignored when empty)
//   o_rdata    - registered head word
//   o_full, o_empty, o_count - occupancy
module prng_sync_fifo
    import prng_pkg::*;
#(
    parameter int DEPTH = prng_pkg::DEPTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  word_t                    i_wdata,
    input  logic                     i_pop,
    output word_t                    o_rdata,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0] ONE_CNT  = (PTR_W+1)'(1);

    word_t            r_mem [DEPTH];
    logic [PTR_W-1:0] r_rd_ptr, r_wr_ptr;
    logic [PTR_W:0]   r_count;
    word_t            r_rdata;

    logic             w_full, w_empty, w_push, w_pop;
    logic [PTR_W-1:0] w_rd_nxt;

    assign w_full   = (r_count == FULL_CNT);
    assign w_empty  = (r_count == '0);
    assign w_pop    = i_pop && !w_empty;
    // A pop frees the slot the push lands in, so full-with-pop still accepts.
    assign w_push   = i_push && (!w_full || w_pop);
    assign w_rd_nxt = r_rd_ptr + 1'b1;

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_wdata;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_rdata  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= w_rd_nxt;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            // Head register: after a pop the next stored word becomes head;
            // if the queue would otherwise be empty the incoming word does.
            if (w_pop && (r_count > ONE_CNT))
                r_rdata <= r_mem[w_rd_nxt];
            else if (w_push && (w_empty || w_pop))
                r_rdata <= i_wdata;
        end
    end

    assign o_rdata = r_rdata;
    assign o_full  = w_full;
    assign o_empty = w_empty;
    assign o_count = r_count;
endmodule

// File: rtl/prng_word_packer.sv
// prng_word_packer
// Packs consecutive valid PRNG bytes into 32-bit words (first byte in
// [7:0]), queues them in a small FIFO and offers them on a valid/ready
// stream. The source cannot stall, so a word completing into a full FIFO
// without a same-cycle pop is dropped and counted (saturating at 255).
// Optional repetition-count health test, compiled in with PRNG_HEALTH_EN:
// RCT_LIMIT identical samples in a row latch health_fail_o until reset.
//   clk, rst_n - clock, synchronous active-low reset
//   bus        - sample input, word stream, fill/drop/health status
module prng_word_packer
    import prng_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    prng_word_packer_if.slave   bus
);
    logic [IDX_W-1:0] r_idx;
    word_t            r_sr;
    logic [7:0]       r_drop;

    word_t            w_word, w_rdata;
    logic             w_accept, w_complete, w_push, w_pop, w_drop;
    logic             w_full, w_empty;
    logic             w_blocked, w_discard, w_fail;
    logic [FILL_W-1:0] w_count;

`ifdef PRNG_HEALTH_EN
    sample_t    r_prev;
    logic [7:0] r_rep;
    logic       r_fail;
    logic [7:0] w_rep_nxt;
    logic       w_trip;

    // rep==0 means no previous sample yet, so the first one starts a run.
    always_comb begin
        w_rep_nxt = 8'd1;
        if (r_rep != 8'd0 && bus.sample_i == r_prev)
            w_rep_nxt = (r_rep == 8'hFF) ? r_rep : r_rep + 8'd1;
    end

    assign w_trip = bus.sample_valid_i && !r_fail && (w_rep_nxt == 8'(RCT_LIMIT));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_prev <= '0;
            r_rep  <= '0;
            r_fail <= 1'b0;
        end else if (bus.sample_valid_i && !r_fail) begin
            r_prev <= bus.sample_i;
            r_rep  <= w_rep_nxt;
            if (w_trip) r_fail <= 1'b1;
        end
    end

    // The tripping sample is not packed and the partial word is thrown away;
    // afterwards nothing is packed, so the cleared partial stays cleared.
    assign w_blocked = r_fail || w_trip;
    assign w_discard = w_trip;
    assign w_fail    = r_fail;
`else
    assign w_blocked = 1'b0;
    assign w_discard = 1'b0;
    assign w_fail    = 1'b0;
`endif

    assign w_accept   = bus.sample_valid_i && !w_blocked;
    assign w_complete = w_accept && (r_idx == IDX_W'(PACK-1));

    always_comb begin
        w_word = r_sr;
        w_word[r_idx*SAMPLE_W +: SAMPLE_W] = bus.sample_i;
    end

    assign w_pop  = !w_empty && bus.word_ready_i;
    assign w_push = w_complete && (!w_full || w_pop);
    assign w_drop = w_complete && !w_push;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_idx  <= '0;
            r_sr   <= '0;
            r_drop <= '0;
        end else begin
            if (w_discard) begin
                r_idx <= '0;
                r_sr  <= '0;
            end else if (w_accept) begin
                if (w_complete) begin
                    r_idx <= '0;
                    r_sr  <= '0;
                end else begin
                    r_idx <= r_idx + 1'b1;
                    r_sr  <= w_word;
                end
            end
            if (w_drop && r_drop != 8'hFF) r_drop <= r_drop + 8'd1;
        end
    end

    prng_sync_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_wdata (w_word),
        .i_pop   (w_pop),
        .o_rdata (w_rdata),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    assign bus.word_o        = w_rdata;
    assign bus.word_valid_o  = !w_empty;
    assign bus.fill_o        = w_count;
    assign bus.drop_cnt_o    = r_drop;
    assign bus.health_fail_o = w_fail;
endmodule
